csr_cmd_ctrl: RTL

Byte-level command sequencer between the SPI slave block and the CSR register file. It decodes each command byte received over SPI, issues single-cycle read or write strobes to the CSR array, and hands read data back to the SPI block for transmission. Optionally it streams multiple bytes per frame with address auto-increment.

---
 rtl/csr_cmd_ctrl_if.sv | 29 ++
 rtl/csr_cmd_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/csr_cmd_ctrl_if.sv
// SPI-side byte handshake and CSR-side access bus for csr_cmd_ctrl.
// slave = the sequencer, master = SPI block plus CSR file seen from outside.
interface csr_cmd_ctrl_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8
);
  logic                  frame;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_rdy;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_latch;
  logic [ADDR_WIDTH-1:0] csr_addr;
  logic [DATA_WIDTH-1:0] csr_wdata;
  logic                  csr_we;
  logic                  csr_re;
  logic [DATA_WIDTH-1:0] csr_rdata;
  logic                  busy;
  logic                  err;

  modport slave (
    input  frame, data_in, data_rdy, csr_rdata,
    output data_out, data_latch, csr_addr, csr_wdata, csr_we, csr_re, busy, err
  );

  modport master (
    output frame, data_in, data_rdy, csr_rdata,
    input  data_out, data_latch, csr_addr, csr_wdata, csr_we, csr_re, busy, err
  );
endinterface

// File: rtl/csr_cmd_ctrl.sv
// SPI command-byte sequencer driving single-cycle CSR read/write strobes.
// Define CSR_BURST_EN to stream multiple accesses per frame with address auto-increment.
module csr_cmd_ctrl #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 32
) (
  input logic           clk,
  input logic           rst,
  csr_cmd_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, CMD, WR_DATA, RD_REQ, RD_WAIT, RD_OUT, HOLD
  } state_t;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;

  state_t                state_reg;
  logic [1:0]            op_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] data_out_reg;
  logic                  data_latch_reg;
  logic [ADDR_WIDTH-1:0] csr_addr_reg;
  logic [DATA_WIDTH-1:0] csr_wdata_reg;
  logic                  csr_we_reg;
  logic                  csr_re_reg;
  logic                  busy_reg;
  logic                  err_reg;

  logic [1:0]            cmd_op;
  logic [ADDR_WIDTH-1:0] cmd_addr;

  assign cmd_op   = bus.data_in[DATA_WIDTH-1 -: 2];
  assign cmd_addr = bus.data_in[ADDR_WIDTH-1:0];

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return (32'(a) < DEPTH);
  endfunction

`ifdef CSR_BURST_EN
  // Wrap at the last implemented location rather than at the field width.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
    return (32'(a) == DEPTH - 1) ? '0 : a + ADDR_WIDTH'(1);
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      op_reg         <= OP_NOP;
      addr_reg       <= '0;
      data_out_reg   <= '0;
      data_latch_reg <= 1'b0;
      csr_addr_reg   <= '0;
      csr_wdata_reg  <= '0;
      csr_we_reg     <= 1'b0;
      csr_re_reg     <= 1'b0;
      busy_reg       <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      csr_we_reg     <= 1'b0;
      csr_re_reg     <= 1'b0;
      data_latch_reg <= 1'b0;
      if (!bus.frame) begin
        // Dropping chip-select aborts everything; strobes above are already cleared.
        state_reg <= IDLE;
        busy_reg  <= 1'b0;
      end else begin
        busy_reg <= 1'b1;
        case (state_reg)
          IDLE: state_reg <= CMD;
          CMD: begin
            if (bus.data_rdy) begin
              op_reg   <= cmd_op;
              addr_reg <= cmd_addr;
              case (cmd_op)
                OP_READ: begin
                  state_reg    <= RD_REQ;
                  csr_addr_reg <= cmd_addr;
                  csr_re_reg   <= in_range(cmd_addr);
                  if (!in_range(cmd_addr)) err_reg <= 1'b1;
                end
                OP_WRITE: state_reg <= WR_DATA;
                OP_NOP: begin
                  state_reg <= HOLD;
                  if (cmd_addr == '0) err_reg <= 1'b0;
                end
                default: begin
                  state_reg <= HOLD;
                  err_reg   <= 1'b1;
                end
              endcase
            end
          end
          WR_DATA: begin
            if (bus.data_rdy) begin
              csr_addr_reg  <= addr_reg;
              csr_wdata_reg <= bus.data_in;
              csr_we_reg    <= in_range(addr_reg);
              if (!in_range(addr_reg)) err_reg <= 1'b1;
`ifdef CSR_BURST_EN
              state_reg <= WR_DATA;
              addr_reg  <= next_addr(addr_reg);
`else
              state_reg <= HOLD;
`endif
            end
          end
          RD_REQ: state_reg <= RD_WAIT;
          RD_WAIT: begin
            // Out-of-range reads return zero but still hand a byte to the SPI block.
            data_out_reg   <= in_range(addr_reg) ? bus.csr_rdata : '0;
            data_latch_reg <= 1'b1;
            state_reg      <= RD_OUT;
          end
          RD_OUT: state_reg <= HOLD;
          HOLD: begin
`ifdef CSR_BURST_EN
            // The dummy byte after a read's data_latch triggers the next sequential read.
            if (bus.data_rdy && op_reg == OP_READ) begin
              state_reg    <= RD_REQ;
              addr_reg     <= next_addr(addr_reg);
              csr_addr_reg <= next_addr(addr_reg);
              csr_re_reg   <= in_range(next_addr(addr_reg));
              if (!in_range(next_addr(addr_reg))) err_reg <= 1'b1;
            end
`endif
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign bus.data_out   = data_out_reg;
  assign bus.data_latch = data_latch_reg;
  assign bus.csr_addr   = csr_addr_reg;
  assign bus.csr_wdata  = csr_wdata_reg;
  assign bus.csr_we     = csr_we_reg;
  assign bus.csr_re     = csr_re_reg;
  assign bus.busy       = busy_reg;
  assign bus.err        = err_reg;

endmodule
